// File: rtl/sr_cmd_debouncer_pkg.sv
// Shared types and helpers for the SR-latch command stage: FSM state encoding
// and a width helper for the shared pulse/holdoff timer.
`timescale 1ns/1ps
`default_nettype none

package sr_cmd_debouncer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PULSE_S = 2'd1,
    ST_PULSE_R = 2'd2,
    ST_HOLDOFF = 2'd3
  } state_e;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

`default_nettype wire

// File: rtl/sr_btn_debounce.sv
// One push-button channel: 2-flop synchroniser, stable-level debounce counter
// and a one-cycle request on each debounced press (0->1 only).
`timescale 1ns/1ps
`default_nettype none

module sr_btn_debounce #(
  parameter int DEB_CYCLES = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_i,
  output logic req_o
);

  localparam int            CW       = $clog2(DEB_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYCLES - 1);

  logic [1:0]    sync_q;
  logic          deb_q, deb_d;
  logic          deb_prev_q;
  logic [CW-1:0] cnt_q, cnt_d;

  // Counter only runs while the synchronised level disagrees with deb_q.
  always_comb begin
    deb_d = deb_q;
    cnt_d = '0;
    if (sync_q[1] != deb_q) begin
      if (cnt_q == CNT_LAST) begin
        deb_d = sync_q[1];
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q     <= 2'b00;
      deb_q      <= 1'b0;
      deb_prev_q <= 1'b0;
      cnt_q      <= '0;
    end else begin
      sync_q     <= {sync_q[0], btn_i};
      deb_q      <= deb_d;
      deb_prev_q <= deb_q;
      cnt_q      <= cnt_d;
    end
  end

  assign req_o = deb_q & ~deb_prev_q;

endmodule

`default_nettype wire

// File: rtl/sr_cmd_debouncer.sv
// SR-latch command stage: debounced set/reset buttons become mutually
// exclusive, fixed-width s/r pulses separated by a holdoff dead time.
`timescale 1ns/1ps
`default_nettype none

module sr_cmd_debouncer
  import sr_cmd_debouncer_pkg::*;
#(
  parameter int DEB_CYCLES     = 16,
  parameter int PULSE_CYCLES   = 4,
  parameter int HOLDOFF_CYCLES = 8,
  parameter int RST_PRIORITY   = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_s,
  input  logic btn_r,
  output logic s,
  output logic r,
  output logic busy,
  output logic conflict
);

  localparam int            TW         = $clog2(max2(PULSE_CYCLES, HOLDOFF_CYCLES) + 1);
  localparam logic [TW-1:0] PULSE_LOAD = TW'(PULSE_CYCLES - 1);
  localparam logic [TW-1:0] HOLD_LOAD  = TW'(HOLDOFF_CYCLES - 1);

  logic req_s, req_r;

  sr_btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_s (
    .clk   (clk),
    .rst_n (rst_n),
    .btn_i (btn_s),
    .req_o (req_s)
  );

  sr_btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_r (
    .clk   (clk),
    .rst_n (rst_n),
    .btn_i (btn_r),
    .req_o (req_r)
  );

  state_e        state_q, state_d;
  logic [TW-1:0] tcnt_q, tcnt_d;
  logic          pend_s_q, pend_s_d;
  logic          pend_r_q, pend_r_d;
  logic          start_s, start_r;
  logic          conflict_d;
  logic          s_q, r_q, busy_q, conflict_q;

  always_comb begin
    state_d    = state_q;
    tcnt_d     = tcnt_q;
    start_s    = 1'b0;
    start_r    = 1'b0;
    conflict_d = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (pend_s_q && pend_r_q) begin
          conflict_d = 1'b1;
          if (RST_PRIORITY != 0) start_r = 1'b1;
          else                   start_s = 1'b1;
        end else if (pend_s_q) begin
          start_s = 1'b1;
        end else if (pend_r_q) begin
          start_r = 1'b1;
        end
        if (start_s) begin
          state_d = ST_PULSE_S;
          tcnt_d  = PULSE_LOAD;
        end else if (start_r) begin
          state_d = ST_PULSE_R;
          tcnt_d  = PULSE_LOAD;
        end
      end
      ST_PULSE_S, ST_PULSE_R: begin
        if (tcnt_q == '0) begin
          state_d = ST_HOLDOFF;
          tcnt_d  = HOLD_LOAD;
        end else begin
          tcnt_d = tcnt_q - 1'b1;
        end
      end
      ST_HOLDOFF: begin
        if (tcnt_q == '0) begin
          state_d = ST_IDLE;
          tcnt_d  = '0;
        end else begin
          tcnt_d = tcnt_q - 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        tcnt_d  = '0;
      end
    endcase
  end

  // A request landing on the same edge its pulse starts is a new press and re-arms the flag.
  assign pend_s_d = (pend_s_q & ~start_s) | req_s;
  assign pend_r_d = (pend_r_q & ~start_r) | req_r;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      tcnt_q     <= '0;
      pend_s_q   <= 1'b0;
      pend_r_q   <= 1'b0;
      s_q        <= 1'b0;
      r_q        <= 1'b0;
      busy_q     <= 1'b0;
      conflict_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      tcnt_q     <= tcnt_d;
      pend_s_q   <= pend_s_d;
      pend_r_q   <= pend_r_d;
      s_q        <= (state_d == ST_PULSE_S);
      r_q        <= (state_d == ST_PULSE_R);
      busy_q     <= (state_d != ST_IDLE);
      conflict_q <= conflict_d;
    end
  end

  assign s        = s_q;
  assign r        = r_q;
  assign busy     = busy_q;
  assign conflict = conflict_q;

endmodule

`default_nettype wire

// File: tb/tb_sr_cmd_debouncer.sv
// Scoreboard bench for sr_cmd_debouncer: stimulus queues expected pulse starts,
// a monitor pops and checks them, plus width, busy length and s/r exclusivity.
`timescale 1ns/1ps
`default_nettype none

module tb_sr_cmd_debouncer;

  typedef struct {
    int dut;
    bit chan;   // 0 = s, 1 = r
    int cyc;
    bit conf;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [2:0] bs, br;
  wire  [2:0] s_w, r_w, busy_w, conf_w;

  int   cyc    = 0;
  int   errors = 0;
  int   checks = 0;
  exp_t sb[$];
  int   bw_exp[3] = '{5, 5, 22};

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // dut 0: reset priority, dut 1: set priority, dut 2: long holdoff
  sr_cmd_debouncer #(.DEB_CYCLES(4), .PULSE_CYCLES(2), .HOLDOFF_CYCLES(3), .RST_PRIORITY(1)) u_dut_p1 (
    .clk(clk), .rst_n(rst_n), .btn_s(bs[0]), .btn_r(br[0]),
    .s(s_w[0]), .r(r_w[0]), .busy(busy_w[0]), .conflict(conf_w[0])
  );
  sr_cmd_debouncer #(.DEB_CYCLES(4), .PULSE_CYCLES(2), .HOLDOFF_CYCLES(3), .RST_PRIORITY(0)) u_dut_p0 (
    .clk(clk), .rst_n(rst_n), .btn_s(bs[1]), .btn_r(br[1]),
    .s(s_w[1]), .r(r_w[1]), .busy(busy_w[1]), .conflict(conf_w[1])
  );
  sr_cmd_debouncer #(.DEB_CYCLES(4), .PULSE_CYCLES(2), .HOLDOFF_CYCLES(20), .RST_PRIORITY(1)) u_dut_lh (
    .clk(clk), .rst_n(rst_n), .btn_s(bs[2]), .btn_r(br[2]),
    .s(s_w[2]), .r(r_w[2]), .busy(busy_w[2]), .conflict(conf_w[2])
  );

  task automatic chk(input string nm, input int d, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s dut%0d: got %0d, expected %0d (cycle %0d)", nm, d, got, exp, cyc);
    end
  endtask

  task automatic push(input int d, input bit ch, input int c, input bit cf);
    exp_t e;
    e.dut  = d;
    e.chan = ch;
    e.cyc  = c;
    e.conf = cf;
    sb.push_back(e);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  // Monitor
  logic [2:0] ps = '0, pr = '0;
  int hi[3] = '{0, 0, 0};
  int bz[3] = '{0, 0, 0};

  always @(posedge clk) begin
    #1;
    if (!rst_n) begin
      ps = '0;
      pr = '0;
      for (int d = 0; d < 3; d++) begin
        hi[d] = 0;
        bz[d] = 0;
      end
    end else begin
      for (int d = 0; d < 3; d++) begin
        chk("s_and_r", d, int'(s_w[d] & r_w[d]), 0);
        if ((s_w[d] && !ps[d]) || (r_w[d] && !pr[d])) begin
          int   idx;
          exp_t e;
          idx = -1;
          for (int i = 0; i < sb.size(); i++)
            if (idx < 0 && sb[i].dut == d) idx = i;
          chk("pulse_expected", d, (idx >= 0) ? 1 : 0, 1);
          if (idx >= 0) begin
            e = sb[idx];
            sb.delete(idx);
            chk("pulse_chan", d, int'(r_w[d]), int'(e.chan));
            chk("pulse_cycle", d, cyc, e.cyc);
            chk("pulse_conflict", d, int'(conf_w[d]), int'(e.conf));
          end
        end else begin
          chk("stray_conflict", d, int'(conf_w[d]), 0);
        end
        if (s_w[d] || r_w[d]) hi[d]++;
        else if (hi[d] != 0) begin
          chk("pulse_width", d, hi[d], 2);
          hi[d] = 0;
        end
        if (busy_w[d]) bz[d]++;
        else if (bz[d] != 0) begin
          chk("busy_len", d, bz[d], bw_exp[d]);
          bz[d] = 0;
        end
        ps[d] = s_w[d];
        pr[d] = r_w[d];
      end
    end
  end

  int hi_t[8] = '{1, 3, 2, 3, 1, 2, 3, 1};
  int lo_t[8] = '{2, 1, 3, 1, 2, 2, 1, 2};

  initial begin
    int e0;
    rst_n = 1'b0;
    bs    = '0;
    br    = '0;
    tick(3);
    for (int d = 0; d < 3; d++)
      chk("reset_outputs", d, int'({s_w[d], r_w[d], busy_w[d], conf_w[d]}), 0);
    rst_n = 1'b1;
    tick(2);

    // Clean set press
    e0 = cyc; bs[0] = 1'b1; push(0, 0, e0 + 8, 0);
    tick(20); bs[0] = 1'b0; tick(12);

    // Bounce rejection: high runs shorter than the debounce window
    for (int i = 0; i < 8; i++) begin
      bs[0] = 1'b1; tick(hi_t[i]);
      bs[0] = 1'b0; tick(lo_t[i]);
    end
    tick(10);

    // Simultaneous press, reset wins
    e0 = cyc; bs[0] = 1'b1; br[0] = 1'b1;
    push(0, 1, e0 + 8, 1); push(0, 0, e0 + 14, 0);
    tick(25); bs[0] = 1'b0; br[0] = 1'b0; tick(12);

    // Reset request arriving while set pulse is active
    e0 = cyc; bs[0] = 1'b1; push(0, 0, e0 + 8, 0);
    tick(2); br[0] = 1'b1; push(0, 1, e0 + 14, 0);
    tick(25); bs[0] = 1'b0; br[0] = 1'b0; tick(12);

    // Reset mid-pulse with the button still held
    e0 = cyc; bs[0] = 1'b1; push(0, 0, e0 + 8, 0);
    tick(8);
    chk("s_before_reset", 0, int'(s_w[0]), 1);
    rst_n = 1'b0;
    #1;
    chk("s_async_drop", 0, int'(s_w[0]), 0);
    chk("busy_async_drop", 0, int'(busy_w[0]), 0);
    tick(1);
    rst_n = 1'b1;
    e0 = cyc; push(0, 0, e0 + 8, 0);
    tick(20); bs[0] = 1'b0; tick(12);

    // Simultaneous press, set wins
    e0 = cyc; bs[1] = 1'b1; br[1] = 1'b1;
    push(1, 0, e0 + 8, 1); push(1, 1, e0 + 14, 0);
    tick(25); bs[1] = 1'b0; br[1] = 1'b0; tick(12);

    // Second reset press while pend_r is still set merges into one pulse
    e0 = cyc; bs[2] = 1'b1; push(2, 0, e0 + 8, 0);
    tick(2); br[2] = 1'b1; push(2, 1, e0 + 31, 0);
    tick(8);  br[2] = 1'b0;
    tick(6);  br[2] = 1'b1;
    tick(24); bs[2] = 1'b0; br[2] = 1'b0;
    tick(15);

    for (int i = 0; i < 200 && sb.size() != 0; i++) tick(1);
    tick(30);
    chk("scoreboard_empty", 0, sb.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
